// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state/owner encodings and bus-width defaults shared by the memory-port arbiter files
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif

package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF  = `CORE_ADDR_WIDTH;
    localparam int DATA_W_DEF  = `CORE_DATA_WIDTH;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_LSU = 2'd2,
        DRAIN    = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSU  = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store, slave-port and pipeline-control signals around the memory-port arbiter
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                FlushIn;
    logic                HoldReqOut;

    logic                IfReqValid;
    logic [ADDR_W-1:0]   IfAddr;
    logic                IfGnt;
    logic                IfRspValid;
    logic                IfRspErr;
    logic [DATA_W-1:0]   IfRData;

    logic                LsuReqValid;
    logic [ADDR_W-1:0]   LsuAddr;
    logic                LsuWrEn;
    logic [DATA_W-1:0]   LsuWData;
    logic [DATA_W/8-1:0] LsuWStrb;
    logic                LsuGnt;
    logic                LsuRspValid;
    logic                LsuRspErr;
    logic [DATA_W-1:0]   LsuRData;

    logic                SlvReq;
    logic [ADDR_W-1:0]   SlvAddr;
    logic                SlvWrEn;
    logic [DATA_W-1:0]   SlvWData;
    logic [DATA_W/8-1:0] SlvWStrb;
    logic                SlvGnt;
    logic                SlvRspValid;
    logic [DATA_W-1:0]   SlvRData;
    logic                SlvAbort;

    // Arbiter side: takes requests and slave responses, drives grants, responses and the slave request
    modport slave (
        input  FlushIn, IfReqValid, IfAddr, LsuReqValid, LsuAddr, LsuWrEn, LsuWData, LsuWStrb,
               SlvGnt, SlvRspValid, SlvRData,
        output HoldReqOut, IfGnt, IfRspValid, IfRspErr, IfRData, LsuGnt, LsuRspValid, LsuRspErr,
               LsuRData, SlvReq, SlvAddr, SlvWrEn, SlvWData, SlvWStrb, SlvAbort
    );

    // Environment side: the core masters and the memory slave seen as one driver
    modport master (
        output FlushIn, IfReqValid, IfAddr, LsuReqValid, LsuAddr, LsuWrEn, LsuWData, LsuWStrb,
               SlvGnt, SlvRspValid, SlvRData,
        input  HoldReqOut, IfGnt, IfRspValid, IfRspErr, IfRData, LsuGnt, LsuRspValid, LsuRspErr,
               LsuRData, SlvReq, SlvAddr, SlvWrEn, SlvWData, SlvWStrb, SlvAbort
    );

endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// arb_timeout_cnt: counts cycles spent waiting on the slave and flags the cycle in which the limit is reached
module arb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count waiting cycles, saturating at the limit; clear wins over enable
    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;

    // Counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    // The current waiting cycle is the TIMEOUT-th one when the count already covers TIMEOUT-1 cycles
    assign expired_o = en_i && cnt_q == CW'(TIMEOUT - 1);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction at a time
// (ARB_ROUND_ROBIN_EN selects alternating grants on collisions instead of fixed LSU priority)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e          state_q, state_d;
    arb_owner_e          lock_q, lock_d, sel;
    logic                pick_lsu;
    logic                granted;
    logic                expired;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic [DATA_W/8-1:0] strb_sel;
    logic                wen_sel;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu_q;

    // Remember which master won the latest grant so that collisions alternate
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)       last_lsu_q <= 1'b0;
        else if (granted) last_lsu_q <= sel == OWN_LSU;

    // On a collision the master not granted last wins
    always_comb pick_lsu = bus.LsuReqValid && !(bus.IfReqValid && last_lsu_q);
`else
    assign pick_lsu = bus.LsuReqValid;
`endif

    // A locked owner keeps the port until granted; otherwise pick among the live requests
    always_comb sel = !rst_n ? OWN_NONE :
                      lock_q != OWN_NONE ? lock_q :
                      pick_lsu ? OWN_LSU :
                      bus.IfReqValid ? OWN_IF : OWN_NONE;

    assign granted = state_q == IDLE && sel != OWN_NONE && bus.SlvGnt;

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q != IDLE),
        .expired_o (expired)
    );

    // Next state, owner lock, slave request fields and response routing
    always_comb begin
        state_d         = state_q;
        lock_d          = lock_q;
        bus.SlvReq      = 1'b0;
        addr_sel        = '0;
        wdata_sel       = '0;
        strb_sel        = '0;
        wen_sel         = 1'b0;
        bus.IfGnt       = 1'b0;
        bus.LsuGnt      = 1'b0;
        bus.IfRspValid  = 1'b0;
        bus.IfRspErr    = 1'b0;
        bus.IfRData     = '0;
        bus.LsuRspValid = 1'b0;
        bus.LsuRspErr   = 1'b0;
        bus.LsuRData    = '0;
        bus.SlvAbort    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.SlvReq = sel != OWN_NONE;
                addr_sel   = sel == OWN_LSU ? bus.LsuAddr : sel == OWN_IF ? bus.IfAddr : '0;
                wdata_sel  = sel == OWN_LSU ? bus.LsuWData : '0;
                strb_sel   = sel == OWN_LSU ? bus.LsuWStrb : '0;
                wen_sel    = sel == OWN_LSU && bus.LsuWrEn;
                bus.IfGnt  = bus.SlvGnt && sel == OWN_IF;
                bus.LsuGnt = bus.SlvGnt && sel == OWN_LSU;
                lock_d     = (bus.SlvGnt || (bus.FlushIn && sel == OWN_IF)) ? OWN_NONE : sel;
                if (bus.SlvGnt && sel == OWN_LSU)     state_d = WAIT_LSU;
                else if (bus.SlvGnt && sel == OWN_IF) state_d = bus.FlushIn ? DRAIN : WAIT_IF;
            end
            WAIT_IF: begin
                if (bus.SlvRspValid) begin
                    bus.IfRspValid = !bus.FlushIn;
                    bus.IfRData    = bus.FlushIn ? '0 : bus.SlvRData;
                    state_d        = IDLE;
                end else if (expired) begin
                    bus.IfRspValid = !bus.FlushIn;
                    bus.IfRspErr   = !bus.FlushIn;
                    bus.SlvAbort   = 1'b1;
                    state_d        = IDLE;
                end else if (bus.FlushIn) begin
                    state_d = DRAIN;
                end
            end
            WAIT_LSU: begin
                if (bus.SlvRspValid) begin
                    bus.LsuRspValid = 1'b1;
                    bus.LsuRData    = bus.SlvRData;
                    state_d         = IDLE;
                end else if (expired) begin
                    bus.LsuRspValid = 1'b1;
                    bus.LsuRspErr   = 1'b1;
                    bus.SlvAbort    = 1'b1;
                    state_d         = IDLE;
                end
            end
            DRAIN: begin
                if (bus.SlvRspValid || expired) begin
                    bus.SlvAbort = !bus.SlvRspValid;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and owner lock; reset abandons any transaction in flight silently
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= OWN_NONE;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end

    assign bus.SlvAddr    = addr_sel;
    assign bus.SlvWData   = wdata_sel;
    assign bus.SlvWStrb   = strb_sel;
    assign bus.SlvWrEn    = wen_sel;
    assign bus.HoldReqOut = rst_n && (bus.LsuReqValid || state_q == WAIT_LSU) && !bus.LsuRspValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of the memory-port arbiter with TIMEOUT = 4
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    task automatic clear_in;
        bus.FlushIn     = 1'b0;
        bus.IfReqValid  = 1'b0;
        bus.IfAddr      = '0;
        bus.LsuReqValid = 1'b0;
        bus.LsuAddr     = '0;
        bus.LsuWrEn     = 1'b0;
        bus.LsuWData    = '0;
        bus.LsuWStrb    = '0;
        bus.SlvGnt      = 1'b0;
        bus.SlvRspValid = 1'b0;
        bus.SlvRData    = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_slvreq"}, bus.SlvReq, 1'b0);
        chk({tag, "_ifrsp"}, bus.IfRspValid, 1'b0);
        chk({tag, "_lsursp"}, bus.LsuRspValid, 1'b0);
        chk({tag, "_abort"}, bus.SlvAbort, 1'b0);
        chk({tag, "_hold"}, bus.HoldReqOut, 1'b0);
    endtask

    initial begin
        clear_in();
        repeat (2) @(posedge clk);
        look();
        chk_quiet("rst");
        chk("rst_ifgnt", bus.IfGnt, 1'b0);
        chk("rst_slvaddr", bus.SlvAddr, 32'h0);
        rst_n = 1'b1;
        step();

        // Fetch alone, granted at once, answered two cycles later
        bus.IfReqValid = 1'b1; bus.IfAddr = 32'h8000_0000; bus.SlvGnt = 1'b1;
        look();
        chk("t1_ifgnt", bus.IfGnt, 1'b1);
        chk("t1_slvreq", bus.SlvReq, 1'b1);
        chk("t1_slvaddr", bus.SlvAddr, 32'h8000_0000);
        chk("t1_hold0", bus.HoldReqOut, 1'b0);
        step();
        bus.IfReqValid = 1'b0; bus.SlvGnt = 1'b0;
        look();
        chk_quiet("t1_wait");
        step();
        bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h0000_0413;
        look();
        chk("t1_rspv", bus.IfRspValid, 1'b1);
        chk("t1_rdata", bus.IfRData, 32'h0000_0413);
        chk("t1_err", bus.IfRspErr, 1'b0);
        chk("t1_hold2", bus.HoldReqOut, 1'b0);
        step();
        clear_in();

        // Collision: LSU first, then a second collision decided by the arbitration mode
        bus.IfReqValid = 1'b1; bus.IfAddr = 32'hA0; bus.LsuReqValid = 1'b1; bus.LsuAddr = 32'h100; bus.SlvGnt = 1'b1;
        look();
        chk("t2_lsugnt", bus.LsuGnt, 1'b1);
        chk("t2_ifgnt", bus.IfGnt, 1'b0);
        chk("t2_addr", bus.SlvAddr, 32'h100);
        chk("t2_hold", bus.HoldReqOut, 1'b1);
        step();
        bus.LsuReqValid = 1'b0; bus.SlvRspValid = 1'b1; bus.SlvRData = 32'hDEAD_BEEF;
        look();
        chk("t2_lsursp", bus.LsuRspValid, 1'b1);
        chk("t2_lsurdata", bus.LsuRData, 32'hDEAD_BEEF);
        chk("t2_hold_rsp", bus.HoldReqOut, 1'b0);
        chk("t2_ifgnt_wait", bus.IfGnt, 1'b0);
        step();
        bus.SlvRspValid = 1'b0; bus.LsuReqValid = 1'b1; bus.LsuAddr = 32'h104;
        look();
        chk("t2b_ifgnt", bus.IfGnt, RR);
        chk("t2b_lsugnt", bus.LsuGnt, !RR);
        chk("t2b_addr", bus.SlvAddr, RR ? 32'hA0 : 32'h104);
        chk("t2b_hold", bus.HoldReqOut, 1'b1);
        step();
        bus.IfReqValid = !RR; bus.LsuReqValid = RR; bus.SlvGnt = 1'b0; bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h11;
        look();
        chk("t2b_ifrsp", bus.IfRspValid, RR);
        chk("t2b_lsursp", bus.LsuRspValid, !RR);
        step();
        bus.SlvRspValid = 1'b0; bus.SlvGnt = 1'b1;
        look();
        chk("t2c_ifgnt", bus.IfGnt, !RR);
        chk("t2c_lsugnt", bus.LsuGnt, RR);
        step();
        bus.IfReqValid = 1'b0; bus.LsuReqValid = 1'b0; bus.SlvGnt = 1'b0; bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h22;
        look();
        chk("t2c_ifrsp", bus.IfRspValid, !RR);
        chk("t2c_lsursp", bus.LsuRspValid, RR);
        step();
        clear_in();

        // Fetch locked while the slave stalls; a later LSU request must not steal the port
        bus.IfReqValid = 1'b1; bus.IfAddr = 32'h200;
        look();
        chk("t3_slvreq", bus.SlvReq, 1'b1);
        chk("t3_addr0", bus.SlvAddr, 32'h200);
        step();
        bus.LsuReqValid = 1'b1; bus.LsuAddr = 32'h300; bus.LsuWrEn = 1'b1; bus.LsuWData = 32'hCAFE_F00D; bus.LsuWStrb = 4'hF;
        look();
        chk("t3_addr1", bus.SlvAddr, 32'h200);
        chk("t3_wren1", bus.SlvWrEn, 1'b0);
        chk("t3_hold1", bus.HoldReqOut, 1'b1);
        step();
        look();
        chk("t3_addr2", bus.SlvAddr, 32'h200);
        step();
        bus.SlvGnt = 1'b1;
        look();
        chk("t3_ifgnt", bus.IfGnt, 1'b1);
        chk("t3_lsugnt3", bus.LsuGnt, 1'b0);
        chk("t3_addr3", bus.SlvAddr, 32'h200);
        step();
        bus.IfReqValid = 1'b0; bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h33;
        look();
        chk("t3_ifrsp", bus.IfRspValid, 1'b1);
        chk("t3_lsugnt4", bus.LsuGnt, 1'b0);
        step();
        bus.SlvRspValid = 1'b0;
        look();
        chk("t3_lsugnt5", bus.LsuGnt, 1'b1);
        chk("t3_addr5", bus.SlvAddr, 32'h300);
        chk("t3_wren5", bus.SlvWrEn, 1'b1);
        chk("t3_wdata5", bus.SlvWData, 32'hCAFE_F00D);
        chk("t3_strb5", bus.SlvWStrb, 4'hF);
        step();
        bus.LsuReqValid = 1'b0; bus.SlvGnt = 1'b0; bus.SlvRspValid = 1'b1;
        look();
        chk("t3_lsursp", bus.LsuRspValid, 1'b1);
        chk("t3_hold6", bus.HoldReqOut, 1'b0);
        step();
        clear_in();

        // Flush after a fetch grant: the late response is drained silently
        bus.IfReqValid = 1'b1; bus.IfAddr = 32'h400; bus.SlvGnt = 1'b1;
        look();
        chk("t4_ifgnt", bus.IfGnt, 1'b1);
        step();
        bus.IfReqValid = 1'b0; bus.SlvGnt = 1'b0; bus.FlushIn = 1'b1;
        look();
        chk_quiet("t4_flush");
        step();
        bus.FlushIn = 1'b0;
        look();
        chk("t4_drain_rsp", bus.IfRspValid, 1'b0);
        step();
        bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h44;
        look();
        chk("t4_dropped", bus.IfRspValid, 1'b0);
        chk("t4_noabort", bus.SlvAbort, 1'b0);
        step();
        bus.SlvRspValid = 1'b0; bus.IfReqValid = 1'b1; bus.IfAddr = 32'h404; bus.SlvGnt = 1'b1;
        look();
        chk("t4_regnt", bus.IfGnt, 1'b1);
        chk("t4_readdr", bus.SlvAddr, 32'h404);
        step();
        bus.IfReqValid = 1'b0; bus.SlvGnt = 1'b0; bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h55;
        look();
        chk("t4_rsp", bus.IfRspValid, 1'b1);
        chk("t4_rdata", bus.IfRData, 32'h55);
        step();
        clear_in();

        // Flush coincident with the response: dropped, straight back to IDLE
        bus.IfReqValid = 1'b1; bus.IfAddr = 32'h600; bus.SlvGnt = 1'b1;
        step();
        bus.IfReqValid = 1'b0; bus.SlvGnt = 1'b0; bus.FlushIn = 1'b1; bus.SlvRspValid = 1'b1;
        look();
        chk("t6_dropped", bus.IfRspValid, 1'b0);
        step();
        bus.FlushIn = 1'b0; bus.SlvRspValid = 1'b0; bus.IfReqValid = 1'b1; bus.IfAddr = 32'h604; bus.SlvGnt = 1'b1;
        look();
        chk("t6_idle_gnt", bus.IfGnt, 1'b1);
        step();
        bus.IfReqValid = 1'b0; bus.SlvGnt = 1'b0; bus.SlvRspValid = 1'b1;
        look();
        chk("t6_rsp", bus.IfRspValid, 1'b1);
        step();
        // A second response with nothing outstanding is ignored
        look();
        chk_quiet("t6_spurious");
        step();
        clear_in();

        // Store with no response times out on the fourth waiting cycle
        bus.LsuReqValid = 1'b1; bus.LsuWrEn = 1'b1; bus.LsuAddr = 32'h500; bus.LsuWData = 32'h1234; bus.SlvGnt = 1'b1;
        look();
        chk("t5_gnt", bus.LsuGnt, 1'b1);
        step();
        clear_in();
        for (int i = 1; i <= 3; i++) begin
            look();
            chk($sformatf("t5_rsp_w%0d", i), bus.LsuRspValid, 1'b0);
            chk($sformatf("t5_abort_w%0d", i), bus.SlvAbort, 1'b0);
            chk($sformatf("t5_hold_w%0d", i), bus.HoldReqOut, 1'b1);
            step();
        end
        look();
        chk("t5_rspv", bus.LsuRspValid, 1'b1);
        chk("t5_err", bus.LsuRspErr, 1'b1);
        chk("t5_rdata", bus.LsuRData, 32'h0);
        chk("t5_abort", bus.SlvAbort, 1'b1);
        chk("t5_hold", bus.HoldReqOut, 1'b0);
        step();
        look();
        chk_quiet("t5_after");
        step();

        // Response on the would-be timeout cycle wins over the abort
        bus.LsuReqValid = 1'b1; bus.LsuAddr = 32'h510; bus.SlvGnt = 1'b1;
        step();
        clear_in();
        repeat (3) step();
        bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h77;
        look();
        chk("t7_rspv", bus.LsuRspValid, 1'b1);
        chk("t7_err", bus.LsuRspErr, 1'b0);
        chk("t7_rdata", bus.LsuRData, 32'h77);
        chk("t7_abort", bus.SlvAbort, 1'b0);
        step();
        clear_in();

        // Reset in the middle of a load: outputs clear at once, then normal operation
        bus.LsuReqValid = 1'b1; bus.LsuAddr = 32'h700; bus.SlvGnt = 1'b1;
        step();
        clear_in();
        #1;
        chk("t8_hold_before", bus.HoldReqOut, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_quiet("t8_async");
        bus.SlvRspValid = 1'b1;
        look();
        chk("t8_rsp_in_rst", bus.LsuRspValid, 1'b0);
        step();
        bus.SlvRspValid = 1'b0;
        look();
        rst_n = 1'b1;
        step();
        look();
        chk_quiet("t8_released");
        step();
        bus.LsuReqValid = 1'b1; bus.LsuAddr = 32'h704; bus.SlvGnt = 1'b1;
        look();
        chk("t8_gnt", bus.LsuGnt, 1'b1);
        chk("t8_addr", bus.SlvAddr, 32'h704);
        step();
        clear_in();
        bus.SlvRspValid = 1'b1; bus.SlvRData = 32'h88;
        look();
        chk("t8_rsp", bus.LsuRspValid, 1'b1);
        chk("t8_rdata", bus.LsuRData, 32'h88);
        step();
        clear_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
